// File: rtl/rgmii_rx_frame.sv
// RGMII receive framer: DDR capture, byte/nibble assembly, preamble strip, length/error checks, stats.
// Optional in-band PHY status decode is enabled with `define RGMII_INBAND_STATUS_EN.
module rgmii_rx_frame #(
  parameter int MAX_FRAME_LEN = 1522,
  parameter int MIN_FRAME_LEN = 64,
  parameter int LEN_W         = 16,
  parameter int CNT_W         = 32
) (
  input  logic             RXCLK_i,
  input  logic             reset,
  input  logic [3:0]       RXDATA_i,
  input  logic             RXCTL_i,
  input  logic             speed_1g_i,
  output logic             GMII_RX_CLK_o,
  output logic [7:0]       rxd_o,
  output logic             rx_valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic             frame_err_o,
  output logic [2:0]       err_code_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
`ifdef RGMII_INBAND_STATUS_EN
  ,
  output logic             link_up_o,
  output logic [1:0]       link_speed_o,
  output logic             full_duplex_o
`endif
);

  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] L_MIN = LEN_W'(MIN_FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t           r_state;
  logic [3:0]       r_nib_lo, r_nib_hi, r_lo;
  logic             r_dv, r_ctl_n;
  logic             r_mode, r_dv1, r_bv, r_ber, r_phase, r_er_lo, r_half;
  logic [7:0]       r_byte;
  logic [LEN_W-1:0] r_len;
  logic             r_first, r_long, r_phy;
  logic             w_er;
  logic [2:0]       w_code;

  assign GMII_RX_CLK_o = RXCLK_i;
  assign w_er          = r_dv ^ r_ctl_n;
  assign w_code        = {(r_len < L_MIN), r_long, (r_phy | r_half)};

  always_ff @(posedge RXCLK_i) begin
    if (reset) begin
      r_nib_lo <= '0;
      r_dv     <= 1'b0;
    end else begin
      r_nib_lo <= RXDATA_i;
      r_dv     <= RXCTL_i;
    end
  end

  always_ff @(negedge RXCLK_i) begin
    if (reset) begin
      r_nib_hi <= '0;
      r_ctl_n  <= 1'b0;
    end else begin
      r_nib_hi <= RXDATA_i;
      r_ctl_n  <= RXCTL_i;
    end
  end

  // Assembly stage: one byte strobe per completed byte; a dangling nibble at dv fall pulses r_half
  always_ff @(posedge RXCLK_i) begin
    if (reset) begin
      r_mode  <= speed_1g_i;
      r_dv1   <= 1'b0;
      r_bv    <= 1'b0;
      r_ber   <= 1'b0;
      r_byte  <= '0;
      r_phase <= 1'b0;
      r_lo    <= '0;
      r_er_lo <= 1'b0;
      r_half  <= 1'b0;
    end else begin
      r_dv1  <= r_dv;
      r_half <= 1'b0;
      if (r_state == S_IDLE && !r_dv && !r_dv1)
        r_mode <= speed_1g_i;
      if (r_mode) begin
        r_byte  <= {r_nib_hi, r_nib_lo};
        r_bv    <= r_dv;
        r_ber   <= w_er;
        r_phase <= 1'b0;
      end else begin
        r_bv <= 1'b0;
        if (!r_dv) begin
          r_phase <= 1'b0;
          r_half  <= r_phase;
        end else if (!r_phase) begin
          r_lo    <= r_nib_lo;
          r_er_lo <= w_er;
          r_phase <= 1'b1;
        end else begin
          r_byte  <= {r_nib_lo, r_lo};
          r_ber   <= r_er_lo | w_er;
          r_bv    <= 1'b1;
          r_phase <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge RXCLK_i) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_first     <= 1'b0;
      r_long      <= 1'b0;
      r_phy       <= 1'b0;
      rxd_o       <= '0;
      rx_valid_o  <= 1'b0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      frame_len_o <= '0;
      frame_err_o <= 1'b0;
      err_code_o  <= '0;
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      sof_o      <= 1'b0;
      eof_o      <= 1'b0;
      case (r_state)
        S_IDLE: if (r_dv1) r_state <= S_PRE;
        S_PRE: begin
          if (!r_dv1) r_state <= S_DROP;
          else if (r_bv) begin
            if (r_byte == 8'hD5) begin
              r_state <= S_DATA;
              r_len   <= '0;
              r_first <= 1'b1;
              r_long  <= 1'b0;
              r_phy   <= 1'b0;
            end else if (r_byte != 8'h55) begin
              r_state <= S_DROP;
            end
          end
        end
        S_DATA: begin
          if (!r_dv1) begin
            eof_o       <= 1'b1;
            frame_len_o <= r_len;
            err_code_o  <= w_code;
            frame_err_o <= |w_code;
            if (|w_code) err_cnt_o <= err_cnt_o + 1'b1;
            else         frame_cnt_o <= frame_cnt_o + 1'b1;
            r_state <= S_IDLE;
          end else if (r_bv) begin
            r_phy <= r_phy | r_ber;
            if (r_len < L_MAX) begin
              rxd_o      <= r_byte;
              rx_valid_o <= 1'b1;
              sof_o      <= r_first;
              r_first    <= 1'b0;
              r_len      <= r_len + 1'b1;
            end else begin
              r_len  <= L_MAX + 1'b1;
              r_long <= 1'b1;
            end
          end
        end
        S_DROP: if (!r_dv1) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RGMII_INBAND_STATUS_EN
  logic [3:0] r_st_prev;
  logic       r_st_ok;
  logic       w_st_en;

  assign w_st_en = (r_state == S_IDLE) && !r_dv && !w_er;

  always_ff @(posedge RXCLK_i) begin
    if (reset) begin
      r_st_prev     <= '0;
      r_st_ok       <= 1'b0;
      link_up_o     <= 1'b0;
      link_speed_o  <= '0;
      full_duplex_o <= 1'b0;
    end else if (w_st_en) begin
      r_st_prev <= r_nib_lo;
      r_st_ok   <= 1'b1;
      if (r_st_ok && r_st_prev == r_nib_lo) begin
        link_up_o     <= r_nib_lo[0];
        link_speed_o  <= r_nib_lo[2:1];
        full_duplex_o <= r_nib_lo[3];
      end
    end else begin
      r_st_ok <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Scoreboard bench for rgmii_rx_frame: expected bytes/eof records queued at drive time, popped by a negedge monitor.
module tb_rgmii_rx_frame;

  logic        RXCLK_i = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  RXDATA_i = '0;
  logic        RXCTL_i = 1'b0;
  logic        speed_1g_i = 1'b1;
  logic        GMII_RX_CLK_o;
  logic [7:0]  rxd_o;
  logic        rx_valid_o, sof_o, eof_o, frame_err_o;
  logic [15:0] frame_len_o;
  logic [2:0]  err_code_o;
  logic [31:0] frame_cnt_o, err_cnt_o;
`ifdef RGMII_INBAND_STATUS_EN
  logic        link_up_o, full_duplex_o;
  logic [1:0]  link_speed_o;
`endif

  rgmii_rx_frame #(.MAX_FRAME_LEN(1522), .MIN_FRAME_LEN(64), .LEN_W(16), .CNT_W(32)) dut (
    .RXCLK_i(RXCLK_i), .reset(reset), .RXDATA_i(RXDATA_i), .RXCTL_i(RXCTL_i),
    .speed_1g_i(speed_1g_i), .GMII_RX_CLK_o(GMII_RX_CLK_o), .rxd_o(rxd_o),
    .rx_valid_o(rx_valid_o), .sof_o(sof_o), .eof_o(eof_o), .frame_len_o(frame_len_o),
    .frame_err_o(frame_err_o), .err_code_o(err_code_o), .frame_cnt_o(frame_cnt_o),
    .err_cnt_o(err_cnt_o)
`ifdef RGMII_INBAND_STATUS_EN
    , .link_up_o(link_up_o), .link_speed_o(link_speed_o), .full_duplex_o(full_duplex_o)
`endif
  );

  always #4 RXCLK_i = ~RXCLK_i;

  typedef struct { logic [7:0] b; logic sof; } byte_t;
  typedef struct { logic [15:0] len; logic [2:0] code; logic [31:0] fc; logic [31:0] ec; } eof_t;

  byte_t bq[$];
  eof_t  eq[$];
  int    errors = 0, checks = 0;
  int    n_valid = 0, n_eof = 0, cyc = 0, last_cyc = 0, gap_exp = 1;
  bit    have_last = 0, chk_off = 0;
  logic [31:0] exp_fc = '0, exp_ec = '0;

  task automatic mon_step();
    byte_t e;
    eof_t  f;
    cyc++;
    if (chk_off) have_last = 0;
    if (rx_valid_o) begin
      n_valid++;
      if (!chk_off) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h with empty queue", rxd_o);
        end else begin
          e = bq.pop_front();
          if (rxd_o !== e.b || sof_o !== e.sof) begin
            errors++;
            $display("FAIL byte: got %02h sof=%b, want %02h sof=%b", rxd_o, sof_o, e.b, e.sof);
          end
        end
        if (!sof_o && have_last) begin
          checks++;
          if (cyc - last_cyc != gap_exp) begin
            errors++;
            $display("FAIL valid_gap: got %0d cycles, want %0d", cyc - last_cyc, gap_exp);
          end
        end
        last_cyc  = cyc;
        have_last = 1;
      end
    end
    if (eof_o) begin
      n_eof++;
      have_last = 0;
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_eof: len=%0d code=%b", frame_len_o, err_code_o);
      end else begin
        f = eq.pop_front();
        if (frame_len_o !== f.len || err_code_o !== f.code || frame_err_o !== (|f.code) ||
            frame_cnt_o !== f.fc || err_cnt_o !== f.ec) begin
          errors++;
          $display("FAIL eof: got len=%0d code=%b err=%b fc=%0d ec=%0d, want len=%0d code=%b fc=%0d ec=%0d",
                   frame_len_o, err_code_o, frame_err_o, frame_cnt_o, err_cnt_o,
                   f.len, f.code, f.fc, f.ec);
        end
      end
    end
  endtask

  task automatic send_cycle(input logic [3:0] lo, input logic [3:0] hi, input logic dv, input logic er);
    @(negedge RXCLK_i); #1;
    RXDATA_i = lo; RXCTL_i = dv;
    @(posedge RXCLK_i); #1;
    RXDATA_i = hi; RXCTL_i = dv ^ er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_cycle(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er, input bit nib);
    if (nib) begin
      send_cycle(b[3:0], b[3:0], 1'b1, er);
      send_cycle(b[7:4], b[7:4], 1'b1, er);
    end else begin
      send_cycle(b[3:0], b[7:4], 1'b1, er);
    end
  endtask

  task automatic send_frame(input bit nib, input int n, input int er_idx, input bit half, input int ifg);
    eof_t f;
    byte_t e;
    f.len  = 16'((n > 1522) ? 1523 : n);
    f.code = {(n < 64), (n > 1522), ((er_idx >= 0) || half)};
    if (|f.code) exp_ec = exp_ec + 1; else exp_fc = exp_fc + 1;
    f.fc = exp_fc;
    f.ec = exp_ec;
    eq.push_back(f);
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0, nib);
    send_byte(8'hD5, 1'b0, nib);
    for (int i = 0; i < n; i++) begin
      if (i < 1522) begin
        e.b = 8'(i);
        e.sof = (i == 0);
        bq.push_back(e);
      end
      send_byte(8'(i), (i == er_idx), nib);
    end
    if (half) send_cycle(4'hA, 4'hA, 1'b1, 1'b0);
    idle(ifg);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && (bq.size() != 0 || eq.size() != 0); i++) idle(1);
    checks++;
    if (bq.size() != 0 || eq.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d bytes and %0d eofs outstanding, want 0", name, bq.size(), eq.size());
    end
  endtask

  task automatic set_speed(input logic s);
    speed_1g_i = s;
    gap_exp = s ? 1 : 2;
    idle(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if ({rxd_o, rx_valid_o, sof_o, eof_o, frame_len_o, frame_err_o, err_code_o} !== '0 ||
        frame_cnt_o !== '0 || err_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_state: rxd=%02h v=%b sof=%b eof=%b len=%0d err=%b code=%b fc=%0d ec=%0d, want all 0",
               rxd_o, rx_valid_o, sof_o, eof_o, frame_len_o, frame_err_o, err_code_o, frame_cnt_o, err_cnt_o);
    end
`ifdef RGMII_INBAND_STATUS_EN
    checks++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_status: got %b, want 0000", {link_up_o, link_speed_o, full_duplex_o});
    end
`endif
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_byte_basic();
    int v0;
    set_speed(1'b1);
    v0 = n_valid;
    send_frame(1'b0, 64, -1, 1'b0, 12);
    wait_drain("byte_basic");
    checks++;
    if (n_valid - v0 != 64) begin
      errors++;
      $display("FAIL byte_basic count: got %0d valid bytes, want 64", n_valid - v0);
    end
  endtask

  task automatic test_nibble();
    set_speed(1'b0);
    send_frame(1'b1, 64, -1, 1'b0, 12);
    wait_drain("nibble");
  endtask

  task automatic test_long();
    int v0;
    set_speed(1'b1);
    v0 = n_valid;
    send_frame(1'b0, 1530, -1, 1'b0, 12);
    wait_drain("long");
    checks++;
    if (n_valid - v0 != 1522) begin
      errors++;
      $display("FAIL long count: got %0d valid bytes, want 1522", n_valid - v0);
    end
  endtask

  task automatic test_phy_err_short();
    send_frame(1'b0, 40, 10, 1'b0, 12);
    wait_drain("phy_err");
    send_frame(1'b0, 63, -1, 1'b0, 12);
    wait_drain("short63");
  endtask

  task automatic test_nibble_half();
    set_speed(1'b0);
    send_frame(1'b1, 64, -1, 1'b1, 12);
    wait_drain("nibble_half");
    set_speed(1'b1);
  endtask

  task automatic test_drop();
    int v0, e0;
    v0 = n_valid;
    e0 = n_eof;
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h57, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'hD5, 1'b0, 1'b0);
    idle(12);
    checks++;
    if (n_valid != v0 || n_eof != e0 || frame_cnt_o !== exp_fc || err_cnt_o !== exp_ec) begin
      errors++;
      $display("FAIL drop: got +%0d bytes +%0d eofs fc=%0d ec=%0d, want +0 +0 fc=%0d ec=%0d",
               n_valid - v0, n_eof - e0, frame_cnt_o, err_cnt_o, exp_fc, exp_ec);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    e0 = n_eof;
    chk_off = 1;
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b0, 1'b0);
    reset = 1'b1;
    send_byte(8'h0C, 1'b0, 1'b0);
    checks++;
    if ({rx_valid_o, sof_o, eof_o, rxd_o, frame_len_o, err_code_o} !== '0 ||
        frame_cnt_o !== '0 || err_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: v=%b rxd=%02h len=%0d fc=%0d ec=%0d, want all 0",
               rx_valid_o, rxd_o, frame_len_o, frame_cnt_o, err_cnt_o);
    end
    reset = 1'b0;
    exp_fc = '0;
    exp_ec = '0;
    for (int i = 13; i < 40; i++) send_byte(8'(i), 1'b0, 1'b0);
    idle(12);
    chk_off = 0;
    checks++;
    if (n_eof != e0 || frame_cnt_o !== '0 || err_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_after: got +%0d eofs fc=%0d ec=%0d, want +0 0 0",
               n_eof - e0, frame_cnt_o, err_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 64, -1, 1'b0, 2);
    send_frame(1'b0, 65, -1, 1'b0, 12);
    wait_drain("back_to_back");
  endtask

`ifdef RGMII_INBAND_STATUS_EN
  task automatic test_inband();
    for (int i = 0; i < 4; i++) send_cycle(4'b1101, 4'b1101, 1'b0, 1'b0);
    checks++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== {1'b1, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL inband: got link=%b speed=%b dup=%b, want 1 10 1", link_up_o, link_speed_o, full_duplex_o);
    end
    send_cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_cycle(4'b1101, 4'b1101, 1'b0, 1'b0);
    checks++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== {1'b1, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL inband_glitch: got link=%b speed=%b dup=%b, want 1 10 1", link_up_o, link_speed_o, full_duplex_o);
    end
  endtask
`endif

  initial begin
    fork
      forever begin
        @(negedge RXCLK_i);
        mon_step();
      end
    join_none
    test_reset();
    test_byte_basic();
    test_nibble();
    test_long();
    test_phy_err_short();
    test_nibble_half();
    test_drop();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef RGMII_INBAND_STATUS_EN
    test_inband();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
